avalon_pio_master: RTL
======================

Name: avalon_pio_master

Overview:
Avalon-MM initiator that turns a simple command/response handshake into single read and write transfers on the Avalon slave port of a PIO-style register block. It lets an on-fabric controller read and write those registers without the HPS, for example to inject pattern or user key data or to read back status. It handles one outstanding transfer at a time. It honours waitrequest, samples readdata after a fixed read latency, and aborts with an error if waitrequest is held too long.

Parameters:
ADDR_W, 2, width of Avalon word address
DATA_W, 32, width of data bus
READ_LATENCY, 1, cycles from read-accept edge to readdata-valid edge (0..15)
TIMEOUT, 255, max consecutive waitrequest-high cycles before abort (1..65535)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_W  target register address
cmd_wdata  in  DATA_W  write data
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
rsp_rdata  out  DATA_W  read data (0 for writes and errors)
rsp_error  out  1  1 = transfer timed out
avm_address  out  ADDR_W  Avalon address
avm_read  out  1  Avalon read strobe
avm_write  out  1  Avalon write strobe
avm_writedata  out  DATA_W  Avalon write data
avm_readdata  in  DATA_W  Avalon read data
avm_waitrequest  in  1  slave stall
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, immediate): state IDLE. All outputs 0 except cmd_ready=1. Internal counters are 0. A transfer in progress is dropped with no response.
- FSM states: IDLE, XFER, RWAIT, RESP.
- IDLE:
  - cmd_ready=1.
  - On handshake, latch write, addr and wdata, clear the timeout counter, and go to XFER.
- XFER:
  - Drive avm_address from the latched address.
  - Drive avm_write=1 for a write (avm_writedata = latched data) or avm_read=1 for a read (avm_writedata=0).
  - Address and strobe are held stable while avm_waitrequest=1.
  - The transfer is accepted on the edge where the strobe is high and waitrequest=0.
  - Write accepted -> RESP, with rsp_rdata=0 and rsp_error=0.
  - Read accepted:
    - READ_LATENCY=0: latch avm_readdata on the same edge -> RESP.
    - Otherwise: load the latency counter -> RWAIT.
  - Each waitrequest-high edge increments the timeout counter. When the counter reaches TIMEOUT:
    - deassert the strobe;
    - go to RESP with rsp_error=1 and rsp_rdata=0.
- RWAIT:
  - Strobes are 0.
  - The counter decrements each cycle.
  - avm_readdata is latched on the edge READ_LATENCY cycles after the accept edge -> RESP, with rsp_error=0.
- RESP:
  - rsp_valid=1. rsp_rdata and rsp_error are held stable until rsp_ready=1.
  - On handshake -> IDLE.
  - cmd_ready=0, so commands presented during RESP wait.
- Invariants:
  - avm_read and avm_write are never both 1.
  - Strobes are only high in XFER.
  - cmd_ready is only high in IDLE.
- Latency with waitrequest=0 and rsp_ready=1:
  - Write: accept at edge 0, avm_write high in cycle 1, rsp_valid high in cycle 2. Back-to-back throughput is one command per 3 cycles.
  - Read with READ_LATENCY=1: avm_read in cycle 1, readdata sampled at end of cycle 2, rsp_valid in cycle 3.
- Boundary conditions:
  - cmd_valid dropped while busy: ignored.
  - Counter boundary: with TIMEOUT=N, exactly N stall cycles abort, while N-1 stall cycles followed by release succeed.
  - Stall cycles are counted per transfer, not cumulatively.
  - rsp_ready held high in IDLE has no effect.

Test Plan:
- Write addr=0, data=0xA5A5_8000, waitrequest=0 -> avm_write high 1 cycle with avm_address=0 and avm_writedata=0xA5A5_8000; rsp_valid next cycle with rdata=0, error=0.
- Read addr=2, slave returns 0x1234_5678 one cycle after accept (READ_LATENCY=1) -> rsp_rdata=0x1234_5678, error=0, rsp_valid 3 cycles after cmd accept.
- Write with waitrequest high 5 cycles -> avm_write, address and data stable for 6 cycles; single write accepted; response error=0.
- TIMEOUT=8, waitrequest stuck high -> strobe drops after 8 stall cycles; rsp_error=1, rsp_rdata=0. Repeat with release after 7 stall cycles -> success.
- rsp_ready held 0 for 10 cycles, then a new cmd_valid -> rsp fields stable, cmd_ready=0, no bus activity until rsp_ready=1; the next command is then accepted.
- Assert reset mid-XFER -> avm_read/avm_write fall asynchronously, rsp_valid=0, cmd_ready=1; the next command executes normally.

Source files
------------

// File: rtl/avalon_pio_master.sv
// Avalon-MM initiator that turns a command/response handshake into single
// read/write transfers to a PIO-style register block, one transfer at a time.
module avalon_pio_master #(
  parameter int ADDR_W       = 2,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1,
  parameter int TIMEOUT      = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_waitrequest,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, XFER, RWAIT, RESP} state_t;

  localparam bit          LAT0     = (READ_LATENCY == 0);
  localparam logic [3:0]  LAT_LOAD = LAT0 ? 4'd0 : 4'(READ_LATENCY - 1);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic                wr_q;
  logic                err_q;
  logic [15:0]         tmo_cnt_q;
  logic [3:0]          lat_cnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;

  logic cmd_fire;
  logic xfer_accept;
  logic xfer_stall;
  logic tmo_hit;
  logic rd_done;

  assign cmd_fire    = (state_q == IDLE) && cmd_valid;
  assign xfer_accept = (state_q == XFER) && !avm_waitrequest;
  assign xfer_stall  = (state_q == XFER) && avm_waitrequest;
  // The stall that would bring the count up to TIMEOUT is the one that aborts.
  assign tmo_hit     = xfer_stall && (tmo_cnt_q == TMO_LAST);
  assign rd_done     = ((state_q == RWAIT) && (lat_cnt_q == 4'd0)) ||
                       (LAT0 && xfer_accept && !wr_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) state_d = XFER;
      end
      XFER: begin
        if (!avm_waitrequest) begin
          if (wr_q || LAT0) state_d = RESP;
          else              state_d = RWAIT;
        end else if (tmo_hit) begin
          state_d = RESP;
        end
      end
      RWAIT: begin
        if (lat_cnt_q == 4'd0) state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready     = 1'b0;
    rsp_valid     = 1'b0;
    rsp_rdata     = '0;
    rsp_error     = 1'b0;
    avm_address   = '0;
    avm_read      = 1'b0;
    avm_write     = 1'b0;
    avm_writedata = '0;
    busy          = 1'b1;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      XFER: begin
        avm_address = addr_q;
        avm_read    = !wr_q;
        avm_write   = wr_q;
        if (wr_q) avm_writedata = wdata_q;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_rdata = rdata_q;
        rsp_error = err_q;
      end
      default: ;
    endcase
  end

  // Control registers: command type, error flag and the two counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      tmo_cnt_q <= '0;
      lat_cnt_q <= '0;
    end else begin
      if (cmd_fire) wr_q <= cmd_write;

      if (tmo_hit)          err_q <= 1'b1;
      else if (xfer_accept) err_q <= 1'b0;

      if (cmd_fire)        tmo_cnt_q <= '0;
      else if (xfer_stall) tmo_cnt_q <= tmo_cnt_q + 16'd1;

      if (xfer_accept && !wr_q)                        lat_cnt_q <= LAT_LOAD;
      else if ((state_q == RWAIT) && (lat_cnt_q != 0)) lat_cnt_q <= lat_cnt_q - 4'd1;
    end
  end

  // Data registers carry no reset; every output path is gated by state.
  always_ff @(posedge clk) begin
    if (cmd_fire) begin
      addr_q  <= cmd_addr;
      wdata_q <= cmd_wdata;
    end
    if (tmo_hit || (xfer_accept && wr_q)) rdata_q <= '0;
    else if (rd_done)                    rdata_q <= avm_readdata;
  end

endmodule
